// File: rtl/img_pkg.sv
// Shared types and default sizing for the image averaging pipeline.
package img_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int PIX_W_DEF     = 8;
   localparam int OUT_AW_DEF    = 9;
   localparam int OUT_DEPTH_DEF = 512;
   localparam int GROUP_LOG2    = 2;
endpackage

// File: rtl/pixel_avg4_writer_if.sv
// Pixel stream in, result-BRAM write port out, plus frame control/status.
interface pixel_avg4_writer_if
   import img_pkg::*;
#(
   parameter int PIX_W  = PIX_W_DEF,
   parameter int OUT_AW = OUT_AW_DEF
);
   logic              start;
   logic              in_valid;
   logic [PIX_W-1:0]  in_data;
   logic              in_ready;
   logic              wr_en;
   logic [OUT_AW-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              busy;
   logic              done;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/pixel_avg4_writer_avg4_accum.sv
// Sums groups of 2**GROUP_LOG2 accepted pixels and registers the (optionally
// rounded) average together with a one-cycle group_done strobe.
module avg4_accum #(
   parameter int PIX_W      = img_pkg::PIX_W_DEF,
   parameter int GROUP_LOG2 = img_pkg::GROUP_LOG2,
   parameter int ROUND      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             accept,
   input  logic [PIX_W-1:0] data,
   output logic             group_end,
   output logic             group_done,
   output logic [PIX_W-1:0] avg
);
   localparam int SUM_W = PIX_W + GROUP_LOG2;
   localparam logic [SUM_W-1:0] RND = (ROUND != 0) ? (SUM_W'(1) << (GROUP_LOG2 - 1)) : '0;

   logic [GROUP_LOG2-1:0] cnt;
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      sum_nxt;
   logic [SUM_W-1:0]      sum_rnd;

   assign sum_nxt   = sum + SUM_W'(data);
   assign sum_rnd   = sum_nxt + RND;
   assign group_end = accept && (cnt == '1);

   // The closing sample restarts the sum at zero so the next group follows with no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         sum        <= '0;
         group_done <= 1'b0;
         avg        <= '0;
      end else begin
         group_done <= 1'b0;
         if (clr) begin
            cnt <= '0;
            sum <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (group_end) begin
               sum        <= '0;
               group_done <= 1'b1;
               avg        <= sum_rnd[SUM_W-1:GROUP_LOG2];
            end else begin
               sum <= sum_nxt;
            end
         end
      end
   end
endmodule

// File: rtl/pixel_avg4_writer.sv
// Frame engine: averages groups of four pixels and writes one result per group
// to sequential result-BRAM addresses 0..OUT_DEPTH-1.
//
// state | meaning
// IDLE  | waiting for start, outputs hold their last values
// RUN   | accepting pixels, one result-BRAM write per completed group
// DONE  | one-cycle completion pulse, then back to IDLE
module pixel_avg4_writer #(
   parameter int PIX_W      = img_pkg::PIX_W_DEF,
   parameter int OUT_AW     = img_pkg::OUT_AW_DEF,
   parameter int OUT_DEPTH  = img_pkg::OUT_DEPTH_DEF,
   parameter int GROUP_LOG2 = img_pkg::GROUP_LOG2,
   parameter int ROUND      = 1
) (
   input logic                clk,
   input logic                rst,
   pixel_avg4_writer_if.slave bus
);
   img_pkg::state_t   state;
   img_pkg::state_t   state_nxt;
   logic [OUT_AW:0]   grp_left;
   logic [OUT_AW-1:0] wr_cnt;
   logic              wr_en_q;
   logic [OUT_AW-1:0] wr_addr_q;
   logic [PIX_W-1:0]  wr_data_q;
   logic              in_ready;
   logic              busy;
   logic              done;
   logic              clr;
   logic              accept;
   logic              group_end;
   logic              group_done;
   logic [PIX_W-1:0]  avg;
   logic              last_wr;

   assign accept  = bus.in_valid && in_ready;
   assign last_wr = wr_en_q && (wr_addr_q == OUT_AW'(OUT_DEPTH - 1));

   avg4_accum #(
      .PIX_W      (PIX_W),
      .GROUP_LOG2 (GROUP_LOG2),
      .ROUND      (ROUND)
   ) u_accum (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .accept     (accept),
      .data       (bus.in_data),
      .group_end  (group_end),
      .group_done (group_done),
      .avg        (avg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= img_pkg::IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      in_ready  = 1'b0;
      case (state)
         img_pkg::IDLE: begin
            if (bus.start) begin
               state_nxt = img_pkg::RUN;
               clr       = 1'b1;
            end
         end
         img_pkg::RUN: begin
            busy     = 1'b1;
            in_ready = (grp_left != '0);
            if (last_wr) state_nxt = img_pkg::DONE;
         end
         img_pkg::DONE: begin
            done      = 1'b1;
            state_nxt = img_pkg::IDLE;
         end
         default: state_nxt = img_pkg::IDLE;
      endcase
   end

   // grp_left counts groups still to accept so in_ready drops right after the final one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_left  <= '0;
         wr_cnt    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= (state == img_pkg::RUN) && group_done;
         if (clr) begin
            grp_left  <= (OUT_AW + 1)'(OUT_DEPTH);
            wr_cnt    <= '0;
            wr_addr_q <= '0;
         end else begin
            if (group_end) grp_left <= grp_left - 1'b1;
            if ((state == img_pkg::RUN) && group_done) begin
               wr_addr_q <= wr_cnt;
               wr_data_q <= avg;
               wr_cnt    <= wr_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy;
   assign bus.done     = done;
endmodule

// File: tb/tb_pixel_avg4_writer.sv
// Bench for pixel_avg4_writer: a rounding and a truncating instance share one
// stimulus stream; expected writes are queued by the driver and popped by a monitor.
module tb_pixel_avg4_writer;
   localparam int PIX_W     = 8;
   localparam int OUT_AW    = 9;
   localparam int OUT_DEPTH = 512;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       start    = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'd0;

   int   compared   = 0;
   int   mismatched = 0;
   int   acc_cnt    = 0;
   int   phase      = 0;
   exp_t q_r[$];
   exp_t q_t[$];
   logic d1 = 1'b0;
   logic d2 = 1'b0;
   logic done_pend = 1'b0;

   always #5 clk = ~clk;

   pixel_avg4_writer_if #(.PIX_W(PIX_W), .OUT_AW(OUT_AW)) bus_r ();
   pixel_avg4_writer_if #(.PIX_W(PIX_W), .OUT_AW(OUT_AW)) bus_t ();

   assign bus_r.start    = start;
   assign bus_r.in_valid = in_valid;
   assign bus_r.in_data  = in_data;
   assign bus_t.start    = start;
   assign bus_t.in_valid = in_valid;
   assign bus_t.in_data  = in_data;

   pixel_avg4_writer #(
      .PIX_W(PIX_W), .OUT_AW(OUT_AW), .OUT_DEPTH(OUT_DEPTH), .GROUP_LOG2(2), .ROUND(1)
   ) dut_r (
      .clk (clk),
      .rst (rst),
      .bus (bus_r)
   );

   pixel_avg4_writer #(
      .PIX_W(PIX_W), .OUT_AW(OUT_AW), .OUT_DEPTH(OUT_DEPTH), .GROUP_LOG2(2), .ROUND(0)
   ) dut_t (
      .clk (clk),
      .rst (rst),
      .bus (bus_t)
   );

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_group(input int addr, input int exp_round, input int exp_trunc);
      exp_t e;
      e.addr = addr;
      e.data = exp_round;
      q_r.push_back(e);
      e.data = exp_trunc;
      q_t.push_back(e);
   endtask

   task automatic send_sample(input logic [7:0] d);
      logic ok;
      int   t;
      ok = 1'b0;
      t  = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && t < 40) begin
         @(negedge clk);
         ok = bus_r.in_ready;
         step();
         t++;
      end
      in_valid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (bus_r.busy && t < 50);
      if (bus_r.busy) check("idle_timeout", 1, 0);
      step();
   endtask

   // Monitor: wr_en is expected exactly one cycle after each 4th acceptance.
   always @(negedge clk) begin
      logic exp_wr;
      logic exp_done;
      exp_t e;
      exp_wr    = rst ? 1'b0 : d2;
      exp_done  = done_pend;
      done_pend = 1'b0;
      d2 = d1;
      d1 = 1'b0;
      if (rst) begin
         d2    = 1'b0;
         phase = 0;
      end else if (in_valid && bus_r.in_ready) begin
         acc_cnt++;
         phase = (phase + 1) % 4;
         if (phase == 0) d1 = 1'b1;
      end
      if (bus_r.wr_en || exp_wr) check("wr_en_timing_round", int'(bus_r.wr_en), int'(exp_wr));
      if (bus_t.wr_en || exp_wr) check("wr_en_timing_trunc", int'(bus_t.wr_en), int'(exp_wr));
      if (bus_r.done || exp_done) check("done_round", int'(bus_r.done), int'(exp_done));
      if (bus_t.done || exp_done) check("done_trunc", int'(bus_t.done), int'(exp_done));
      if (bus_r.wr_en) begin
         if (q_r.size() == 0) check("unexpected_write_round", 1, 0);
         else begin
            e = q_r.pop_front();
            check("wr_addr_round", int'(bus_r.wr_addr), e.addr);
            check("wr_data_round", int'(bus_r.wr_data), e.data);
            if (e.addr == OUT_DEPTH - 1) done_pend = 1'b1;
         end
      end
      if (bus_t.wr_en) begin
         if (q_t.size() == 0) check("unexpected_write_trunc", 1, 0);
         else begin
            e = q_t.pop_front();
            check("wr_addr_trunc", int'(bus_t.wr_addr), e.addr);
            check("wr_data_trunc", int'(bus_t.wr_data), e.data);
         end
      end
   end

   initial begin
      int base;
      int b;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(bus_r.in_ready), 0);
      check("rst_wr_en",    int'(bus_r.wr_en),    0);
      check("rst_wr_addr",  int'(bus_r.wr_addr),  0);
      check("rst_wr_data",  int'(bus_r.wr_data),  0);
      check("rst_busy",     int'(bus_r.busy),     0);
      check("rst_done",     int'(bus_r.done),     0);
      check("rst_busy_trunc", int'(bus_t.busy),   0);
      step();
      rst = 1'b0;
      step();

      // Frame A: continuous input, stray start near write 100, overrun at the end.
      pulse_start();
      @(negedge clk);
      check("busy_run", int'(bus_r.busy), 1);
      step();
      base = acc_cnt;
      for (int g = 0; g < OUT_DEPTH; g++) begin
         b = (4 * g) % 256;
         push_group(g, b + 2, b + 1);
         if (g == 100) start = 1'b1;
         for (int j = 0; j < 4; j++) begin
            send_sample(8'(b + j));
            start = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("in_ready_after_last", int'(bus_r.in_ready), 0);
         step();
      end
      in_valid = 1'b0;
      wait_idle();
      check("samples_accepted_a", acc_cnt - base, 2048);
      repeat (3) step();
      @(negedge clk);
      check("wr_addr_hold_round", int'(bus_r.wr_addr), OUT_DEPTH - 1);
      check("wr_addr_hold_trunc", int'(bus_t.wr_addr), OUT_DEPTH - 1);
      check("busy_after_done", int'(bus_r.busy), 0);
      step();

      // Frame B: random idle gaps between samples, same reference sequence.
      pulse_start();
      base = acc_cnt;
      for (int g = 0; g < OUT_DEPTH; g++) begin
         b = (4 * g) % 256;
         push_group(g, b + 2, b + 1);
         for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 5)) step();
            send_sample(8'(b + j));
         end
      end
      wait_idle();
      check("samples_accepted_b", acc_cnt - base, 2048);
      check("queue_empty_b", q_r.size(), 0);

      // Frame C: rounding corner groups, then reset mid-group.
      pulse_start();
      push_group(0, 1, 1);
      send_sample(8'd1); send_sample(8'd1); send_sample(8'd1); send_sample(8'd2);
      push_group(1, 255, 255);
      for (int j = 0; j < 4; j++) send_sample(8'd255);
      push_group(2, 1, 0);
      send_sample(8'd0); send_sample(8'd0); send_sample(8'd1); send_sample(8'd1);
      push_group(3, 8, 8);
      for (int j = 0; j < 4; j++) send_sample(8'd8);
      send_sample(8'd200);
      send_sample(8'd200);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy",     int'(bus_r.busy),     0);
      check("midrst_wr_en",    int'(bus_r.wr_en),    0);
      check("midrst_in_ready", int'(bus_r.in_ready), 0);
      check("midrst_wr_addr",  int'(bus_t.wr_addr),  0);
      step();
      rst = 1'b0;
      step();

      // Frame D: first write after reset must use only new samples, at address 0.
      pulse_start();
      push_group(0, 25, 25);
      send_sample(8'd10); send_sample(8'd20); send_sample(8'd30); send_sample(8'd40);
      push_group(1, 4, 3);
      send_sample(8'd3); send_sample(8'd4); send_sample(8'd4); send_sample(8'd4);
      repeat (4) step();
      check("queue_empty_round", q_r.size(), 0);
      check("queue_empty_trunc", q_t.size(), 0);
      rst = 1'b1;
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
